// File: rtl/fifo_gauge_pkg.sv
// Shared types and helpers for the gauged FIFO family: statistics counter
// type and pointer-width calculation.
`default_nettype none

package fifo_gauge_pkg;

  localparam int unsigned STAT_WIDTH = 32;

  typedef logic [STAT_WIDTH-1:0] stat_t;

  // Pointer width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_gauge_bounded_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
`default_nettype none

module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_gauge_bounded.sv
// Bounded valid/ready FIFO with registered output, occupancy gauge,
// high-watermark and saturating upstream stall counter.
`default_nettype none

module fifo_gauge_bounded
  import fifo_gauge_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       idat,
  input  logic                   ivld,
  output logic                   irdy,
  output logic [WIDTH-1:0]       odat,
  output logic                   ovld,
  input  logic                   ordy,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [COUNT_WIDTH-1:0] maxcount,
  output logic [COUNT_WIDTH-1:0] stalls
);

  localparam int unsigned            PTR_W    = ptr_width(DEPTH);
  localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]       odat_q, odat_d;
  logic                   ovld_q, ovld_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] maxcount_q, maxcount_d;

  logic in_xfer;
  logic out_xfer;
  logic load;
  logic buf_avail;
  logic rd_en;
  logic bypass;
  logic wr_en;

  assign irdy = rst && (count_q != FULL_CNT);

  always_comb begin
    in_xfer  = ivld && irdy;
    out_xfer = ovld_q && ordy;
    load     = !ovld_q || ordy;
    // Items still in the circular buffer: occupancy minus the output register.
    buf_avail = count_q > COUNT_WIDTH'(ovld_q);
    rd_en     = load && buf_avail;
    bypass    = load && !buf_avail && in_xfer;
    wr_en     = in_xfer && !bypass;

    count_d = count_q + COUNT_WIDTH'(in_xfer) - COUNT_WIDTH'(out_xfer);

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    odat_d = odat_q;
    ovld_d = ovld_q;
    if (load) begin
      if (buf_avail) begin
        odat_d = mem_q[rd_ptr_q];
        ovld_d = 1'b1;
      end else if (in_xfer) begin
        odat_d = idat;
        ovld_d = 1'b1;
      end else begin
        ovld_d = 1'b0;
      end
    end

    if (clr) begin
      maxcount_d = count_d;
    end else if (count_d > maxcount_q) begin
      maxcount_d = count_d;
    end else begin
      maxcount_d = maxcount_q;
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= idat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      odat_q     <= '0;
      ovld_q     <= 1'b0;
      count_q    <= '0;
      maxcount_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      odat_q     <= odat_d;
      ovld_q     <= ovld_d;
      count_q    <= count_d;
      maxcount_q <= maxcount_d;
    end
  end

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_stalls (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .inc_i   (ivld && !irdy),
    .count_o (stalls)
  );

  assign odat     = odat_q;
  assign ovld     = ovld_q;
  assign count    = count_q;
  assign maxcount = maxcount_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_gauge_bounded.sv
// Directed-vector and scoreboard bench for fifo_gauge_bounded (DEPTH=4 and DEPTH=5 instances).
`default_nettype none

module tb_fifo_gauge_bounded;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] idat = '0;
  logic       ivld = 1'b0;
  logic       irdy;
  logic [7:0] odat;
  logic       ovld;
  logic       ordy = 1'b0;
  logic [3:0] count, maxcount, stalls;

  logic       clr5 = 1'b0;
  logic [7:0] idat5 = '0;
  logic       ivld5 = 1'b0;
  logic       irdy5;
  logic [7:0] odat5;
  logic       ovld5;
  logic       ordy5 = 1'b0;
  logic [7:0] count5, maxcount5, stalls5;

  always #5 clk = ~clk;

  fifo_gauge_bounded #(.WIDTH(8), .DEPTH(4), .COUNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .idat(idat), .ivld(ivld), .irdy(irdy),
    .odat(odat), .ovld(ovld), .ordy(ordy), .count(count), .maxcount(maxcount),
    .stalls(stalls)
  );

  fifo_gauge_bounded #(.WIDTH(8), .DEPTH(5), .COUNT_WIDTH(8)) u_dut5 (
    .clk(clk), .rst(rst), .clr(clr5), .idat(idat5), .ivld(ivld5), .irdy(irdy5),
    .odat(odat5), .ovld(ovld5), .ordy(ordy5), .count(count5), .maxcount(maxcount5),
    .stalls(stalls5)
  );

  typedef struct {
    logic       ivld;
    logic [7:0] idat;
    logic       ordy;
    logic       clr;
    logic       e_irdy;
    logic       e_ovld;
    logic [7:0] e_odat;
    logic [3:0] e_count;
    logic [3:0] e_max;
    logic [3:0] e_stalls;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] id, input logic od, input logic cl,
                     input logic er, input logic ev, input logic [7:0] eo,
                     input logic [3:0] ec, input logic [3:0] em, input logic [3:0] es);
    vec_t v;
    v.ivld = iv; v.idat = id; v.ordy = od; v.clr = cl;
    v.e_irdy = er; v.e_ovld = ev; v.e_odat = eo;
    v.e_count = ec; v.e_max = em; v.e_stalls = es;
    vecs.push_back(v);
  endtask

  task automatic step4(input logic iv, input logic [7:0] id, input logic od);
    @(negedge clk);
    ivld = iv; idat = id; ordy = od; clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sb[$];
  int         mc;
  logic       in_x, out_x;

  initial begin
    // Fill to full with ordy low, two blocked pushes, then drain.
    add(1,8'h01,0,0, 1,1,8'h01,1,1,0);
    add(1,8'h02,0,0, 1,1,8'h01,2,2,0);
    add(1,8'h03,0,0, 1,1,8'h01,3,3,0);
    add(1,8'h04,0,0, 0,1,8'h01,4,4,0);
    add(1,8'h05,0,0, 0,1,8'h01,4,4,1);
    add(1,8'h06,0,0, 0,1,8'h01,4,4,2);
    add(0,8'h00,1,0, 1,1,8'h02,3,4,2);
    add(0,8'h00,1,0, 1,1,8'h03,2,4,2);
    add(0,8'h00,1,0, 1,1,8'h04,1,4,2);
    add(0,8'h00,1,0, 1,0,8'h04,0,4,2);
    // Full with in and out together: one out, none in, then accept.
    add(1,8'h10,0,0, 1,1,8'h10,1,4,2);
    add(1,8'h11,0,0, 1,1,8'h10,2,4,2);
    add(1,8'h12,0,0, 1,1,8'h10,3,4,2);
    add(1,8'h13,0,0, 0,1,8'h10,4,4,2);
    add(1,8'h14,1,0, 1,1,8'h11,3,4,3);
    add(1,8'h14,0,0, 0,1,8'h11,4,4,3);
    add(0,8'h00,1,0, 1,1,8'h12,3,4,3);
    add(0,8'h00,1,0, 1,1,8'h13,2,4,3);
    add(0,8'h00,1,0, 1,1,8'h14,1,4,3);
    add(0,8'h00,1,0, 1,0,8'h14,0,4,3);
    // Watermark clear with one item resident, then refill.
    add(1,8'h20,0,0, 1,1,8'h20,1,4,3);
    add(1,8'h21,0,0, 1,1,8'h20,2,4,3);
    add(1,8'h22,0,0, 1,1,8'h20,3,4,3);
    add(0,8'h00,1,0, 1,1,8'h21,2,4,3);
    add(0,8'h00,1,0, 1,1,8'h22,1,4,3);
    add(0,8'h00,0,1, 1,1,8'h22,1,1,0);
    add(1,8'h23,0,0, 1,1,8'h22,2,2,0);
    add(0,8'h00,1,0, 1,1,8'h23,1,2,0);
    add(0,8'h00,1,0, 1,0,8'h23,0,2,0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("irdy_in_reset", 32'(irdy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_irdy", 32'(irdy), 32'd1);
    chk("rst_ovld", 32'(ovld), 32'd0);
    chk("rst_odat", 32'(odat), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_max", 32'(maxcount), 32'd0);
    chk("rst_stalls", 32'(stalls), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      ivld = vecs[i].ivld; idat = vecs[i].idat; ordy = vecs[i].ordy; clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_irdy", i), 32'(irdy), 32'(vecs[i].e_irdy));
      chk($sformatf("v%0d_ovld", i), 32'(ovld), 32'(vecs[i].e_ovld));
      chk($sformatf("v%0d_odat", i), 32'(odat), 32'(vecs[i].e_odat));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_max", i), 32'(maxcount), 32'(vecs[i].e_max));
      chk($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].e_stalls));
    end

    // Stall counter saturation at 15.
    for (int i = 0; i < 4; i++) step4(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 14; i++) step4(1'b1, 8'h40, 1'b0);
    chk("sat_14", 32'(stalls), 32'd14);
    for (int i = 0; i < 3; i++) begin
      step4(1'b1, 8'h40, 1'b0);
      chk($sformatf("sat_hold%0d", i), 32'(stalls), 32'd15);
    end

    // Asynchronous reset mid-stream.
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_irdy", 32'(irdy), 32'd0);
    chk("arst_ovld", 32'(ovld), 32'd0);
    chk("arst_odat", 32'(odat), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_max", 32'(maxcount), 32'd0);
    chk("arst_stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    ivld = 1'b0; ordy = 1'b0;
    rst = 1'b1;
    #1;
    chk("rel_irdy", 32'(irdy), 32'd1);

    // Streaming pass-through from empty.
    for (int i = 0; i < 100; i++) begin
      step4(1'b1, 8'(i), 1'b1);
      chk($sformatf("stream%0d_odat", i), 32'(odat), 32'(i));
      chk($sformatf("stream%0d_ovld", i), 32'(ovld), 32'd1);
      chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
    end
    chk("stream_max", 32'(maxcount), 32'd1);
    chk("stream_stalls", 32'(stalls), 32'd0);
    step4(1'b0, 8'h00, 1'b1);
    chk("stream_drain", 32'(count), 32'd0);
    ordy = 1'b0;

    // DEPTH=5 random traffic against a queue model.
    mc = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      ivld5 = 1'($urandom_range(0, 1));
      ordy5 = 1'($urandom_range(0, 1));
      idat5 = 8'($urandom);
      #1;
      chk("r_irdy", 32'(irdy5), 32'(mc != 5));
      chk("r_ovld", 32'(ovld5), 32'(mc > 0));
      in_x  = ivld5 && (mc != 5);
      out_x = (mc > 0) && ordy5;
      if (out_x) begin
        chk("r_odat", 32'(odat5), 32'(sb[0]));
        void'(sb.pop_front());
      end
      if (in_x) sb.push_back(idat5);
      @(posedge clk);
      mc = mc + int'(in_x) - int'(out_x);
      #1;
      chk("r_count", 32'(count5), 32'(mc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_gauge_bounded.md
# fifo_gauge_bounded

Bounded, synthesisable FIFO that keeps the fill-level gauging of the simulation-only queue FIFO and adds real depth, backpressure and stall statistics. It sits on any AXI-Stream-style valid/ready link between two dataflow layers and can stay in hardware builds. Its counters give the measured peak occupancy and upstream stall time, so FIFO depths can be sized from real runs. Depth, data width and counter width are parameters.

## Interface
- `WIDTH`, none: data width in bits, ≥1.
- `DEPTH`, none: total capacity in items, output register included; ≥2; need not be a power of two.
- `COUNT_WIDTH`, 32: width of the statistics outputs; must satisfy 2^COUNT_WIDTH > DEPTH.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserts asynchronously, deasserts synchronously to `clk` (the integrator supplies the synchroniser).
- `clr`  in  1  synchronous statistics clear, one-cycle pulse.
- `idat`  in  WIDTH  input data.
- `ivld`  in  1  input valid.
- `irdy`  out  1  input ready.
- `odat`  out  WIDTH  output data, registered.
- `ovld`  out  1  output valid, registered.
- `ordy`  in  1  output ready.
- `count`  out  COUNT_WIDTH  current occupancy.
- `maxcount`  out  COUNT_WIDTH  high watermark of occupancy.
- `stalls`  out  COUNT_WIDTH  cycles with `ivld && !irdy`, saturating.

## Operation
- Input transfer: `ivld && irdy`. Output transfer: `ovld && ordy`.
- Occupancy is the number of accepted items not yet transferred out, including the item in the output register. Range is 0..DEPTH.
- Storage is a circular buffer of DEPTH entries plus the output register. Read and write pointers wrap from DEPTH-1 to 0.
- `irdy = rst && (count != DEPTH)`. There is no full-bypass: when the FIFO is full, an output transfer in the same cycle does not make room for an input in that cycle.
- Output register load: when `!ovld || ordy`, the register takes the oldest buffered item if one exists. Otherwise, if an input transfer occurs this cycle, the input item goes straight into the register. Otherwise `ovld` goes to 0 and `odat` holds its value.
- Ordering is strictly first-in first-out. No item is dropped or duplicated.
- `count_next = count + in_xfer - out_xfer`.
- `maxcount <= max(maxcount, count_next)`, so `maxcount ≥ count` holds at every cycle.
- `stalls` increments each cycle with `ivld && !irdy` while `rst` is high, and saturates at 2^COUNT_WIDTH-1.
- `clr` pulse: `maxcount <= count_next` and `stalls <= 0`. A stall in the same cycle as `clr` is not counted. `clr` does not affect data, pointers or `count`.

## Timing
- Reset values: `ovld`=0, `odat`=0, `count`=0, `maxcount`=0, `stalls`=0, both pointers 0. `irdy` is 0 while `rst` is low and 1 in the first cycle after release.
- Asserting `rst` mid-operation discards all contents immediately. No output transfer completes in that cycle.
- Latency: an item accepted at edge t is on `odat` with `ovld`=1 right after edge t when the FIFO was empty; otherwise it appears behind all earlier items.
- Throughput: one item per cycle in each direction whenever not empty and not full.
- Empty with simultaneous in/out: the input passes through the output register. `count` stays at 1 while streaming.
- `count`, `maxcount` and `stalls` are registered and reflect the state after the most recent edge.

## Structure
- Package `fifo_gauge_pkg`: typedef for the statistics counter type and a `clog2`-based pointer-width constant function. The simulation queue FIFO and this block share both.
- One natural sub-module: `sat_counter` (width parameter; increment, clear, saturate). It is used for `stalls` and is reusable elsewhere.
- The buffer is an inferred register/RAM array. The read path feeds the output register so the RAM read is synchronous.

## Test plan
- DEPTH=4, WIDTH=8, `ordy`=0, push 0x01..0x06 on consecutive cycles:
  - `irdy` drops after the 4th accept and `count`=4, `maxcount`=4.
  - `stalls`=2 after two more blocked cycles.
  - Raising `ordy` yields 0x01..0x04 in order.
- Empty FIFO, `ivld`=`ordy`=1 streaming 0..99: `odat` equals each input delayed one cycle, `count` stays at 1, `maxcount`=1, `stalls`=0.
- DEPTH=5 (non-power-of-two), random `ivld`/`ordy` at 50% for 2000 cycles against a scoreboard: exact order preserved, `count` matches the reference model every cycle, pointers wrap correctly.
- Full FIFO (count=4), `ivld`=`ordy`=1 for one cycle: one item out, none in, `count`=3. The next cycle accepts.
- Fill to 3, drain to 1, pulse `clr`: `maxcount`=1 and `stalls`=0. A later fill to 2 gives `maxcount`=2.
- Force `stalls` to 2^COUNT_WIDTH-2 (COUNT_WIDTH=4) and stall 3 cycles: `stalls` holds at 15. Asserting `rst` mid-stream gives all outputs at reset values and `irdy`=0 asynchronously.
